shift_unit: RTL

Parametrised universal shift register with a start/busy/done handshake, the multi-bit, multi-mode successor to the single-bit left/right shift-select mux. Holds a WIDTH-bit word loaded in parallel, then shifts it left or right by a requested amount in logical, arithmetic, rotate or serial-in mode. Serial (one bit per cycle) by default; single-cycle barrel operation is compile-time selectable. Sits between datapath registers and the control FSM in the lab designs.

---
 rtl/shift_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//   Universal WIDTH-bit shift register with a start/busy/done handshake.
//   The word is loaded in parallel and then shifted left or right by a
//   requested amount. Four modes are supported: logical, arithmetic, rotate
//   and serial-in. By default the unit shifts one bit per clock.
//
//   Compile-time option:
//     SHIFT_UNIT_BARREL_EN  - when defined, the whole N-bit shift is applied
//                             in a single SHIFT cycle (barrel operation).
//                             The q result is the same as in the serial build.
//
//   Ports:
//     clk_i      clock, all logic on the rising edge
//     rst_i      synchronous active-high reset
//     load_i     parallel load of din_i into q_o (accepted in IDLE/DONE)
//     din_i      parallel load data
//     start_i    request a shift (accepted in IDLE/DONE when load_i=0)
//     amount_i   shift count; values above WIDTH clamp to WIDTH
//     lr_i       direction: 1 = left (toward MSB), 0 = right
//     mode_i     00 logical, 01 arithmetic, 10 rotate, 11 serial-in
//     ser_in_i   fill bit for serial-in mode
//     q_o        register contents
//     ser_out_o  last bit shifted out of q
//     busy_o     operation in progress
//     done_o     one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             start_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             lr_i,
  input  logic [1:0]       mode_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] q_q,       q_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [AMT_W-1:0] cnt_q,     cnt_d;
  logic             lr_q,      lr_d;
  logic [1:0]       mode_q,    mode_d;
  logic [AMT_W-1:0] amt_clamped;

  // One single-bit shift step. Returns {bit shifted out, new word}.
  function automatic logic [WIDTH:0] step_f(
    input logic [WIDTH-1:0] v,
    input logic             left,
    input logic [1:0]       md,
    input logic             sin
  );
    logic out_b;
    logic fill_b;
    if (left) begin
      out_b = v[WIDTH-1];
    end else begin
      out_b = v[0];
    end
    case (md)
      2'b00:   fill_b = 1'b0;
      // Arithmetic left behaves like logical left; right replicates the sign.
      2'b01:   fill_b = left ? 1'b0 : v[WIDTH-1];
      2'b10:   fill_b = out_b;
      2'b11:   fill_b = sin;
      default: fill_b = 1'b0;
    endcase
    if (left) begin
      return {out_b, v[WIDTH-2:0], fill_b};
    end else begin
      return {out_b, fill_b, v[WIDTH-1:1]};
    end
  endfunction

`ifdef SHIFT_UNIT_BARREL_EN
  // Full N-bit shift built as a chain of single steps, so the barrel result
  // (word and last bit out) matches the serial datapath bit for bit.
  function automatic logic [WIDTH:0] barrel_f(
    input logic [WIDTH-1:0] v,
    input logic             left,
    input logic [1:0]       md,
    input logic             sin,
    input logic [AMT_W-1:0] n
  );
    logic [WIDTH:0] acc;
    acc = {1'b0, v};
    for (int i = 0; i < WIDTH; i++) begin
      if (AMT_W'(i) < n) begin
        acc = step_f(acc[WIDTH-1:0], left, md, sin);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction
`endif

  // Clamp the requested count to the word width.
  always_comb begin
    if (amount_i > AMT_W'(WIDTH)) begin
      amt_clamped = AMT_W'(WIDTH);
    end else begin
      amt_clamped = amount_i;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    lr_d      = lr_q;
    mode_d    = mode_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        if (load_i) begin
          // load has priority; a simultaneous start is dropped
          q_d     = din_i;
          state_d = S_IDLE;
        end else if (start_i) begin
          lr_d   = lr_i;
          mode_d = mode_i;
          cnt_d  = amt_clamped;
          if (amt_clamped == {AMT_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
`ifdef SHIFT_UNIT_BARREL_EN
        {ser_out_d, q_d} = barrel_f(q_q, lr_q, mode_q, ser_in_i, cnt_q);
        cnt_d   = {AMT_W{1'b0}};
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`else
        {ser_out_d, q_d} = step_f(q_q, lr_q, mode_q, ser_in_i);
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
          busy_d  = 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      q_q       <= {WIDTH{1'b0}};
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= {AMT_W{1'b0}};
      lr_q      <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      lr_q      <= lr_d;
      mode_q    <= mode_d;
    end
  end

  assign q_o       = q_q;
  assign ser_out_o = ser_out_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
